// File: rtl/bithash_job_scheduler_if.sv
// Signal bundle between the job scheduler and its environment: RAH read queue,
// RAH encoder write port and the shared hash-core dispatch/report bus.
interface bithash_job_scheduler_if #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 48
);
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    q_empty;
  logic                    request_data;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    w_en;
  logic                    out_full;
  logic [NUM_CORES-1:0]    core_start;
  logic [31:0]             core_base;
  logic [31:0]             core_len;
  logic [NUM_CORES-1:0]    core_idle;
  logic [NUM_CORES-1:0]    core_found;
  logic [32*NUM_CORES-1:0] core_nonce;
  logic                    busy;

  modport master (
    input  in_data, q_empty, out_full, core_idle, core_found, core_nonce,
    output request_data, out_data, w_en, core_start, core_base, core_len, busy
  );

  modport slave (
    output in_data, q_empty, out_full, core_idle, core_found, core_nonce,
    input  request_data, out_data, w_en, core_start, core_base, core_len, busy
  );
endinterface

// File: rtl/bithash_job_scheduler.sv
// Splits BitHash nonce ranges into chunks dispatched round-robin to hash cores; reports hits/done/errors.
// Latency: first core_start 4 cycles after the START read; hit packet 1 cycle after core_found at best.
// Backpressure: out_full holds all packets (hits first); dispatch waits on core_idle; reads wait on q_empty.
module bithash_job_scheduler #(
  parameter int          NUM_CORES  = 4,
  parameter int          DATA_WIDTH = 48,
  parameter logic [31:0] CHUNK_SIZE = 32'h0010_0000
) (
  input logic                     clk,
  input logic                     rst_n,
  bithash_job_scheduler_if.master bus
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN_REQ, S_LEN, S_DISPATCH, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t               state, state_nx;
  logic [7:0]           job_id;
  logic [7:0]           err_op;
  logic [31:0]          next_base;
  logic [31:0]          remaining;
  logic [31:0]          hit_count;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        hit_ptr;
  logic [NUM_CORES-1:0] pend;
  logic [31:0]          nonce_q [NUM_CORES];
  logic [NUM_CORES-1:0] last_start;

  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  logic                 disp_go;
  logic [31:0]          chunk_len;
  logic                 hit_vld;
  logic [PW-1:0]        hit_idx;
  logic                 hit_go;
  logic [NUM_CORES-1:0] start_w;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NUM_CORES) j = j - NUM_CORES;
    return PW'(j);
  endfunction

  // Dispatch and hit-drain arbiters both search forward from their own pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    hit_vld   = 1'b0;
    hit_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!grant_vld && bus.core_idle[wrap_add(rr_ptr, k)] && !last_start[wrap_add(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(rr_ptr, k);
      end
      if (!hit_vld && pend[wrap_add(hit_ptr, k)]) begin
        hit_vld = 1'b1;
        hit_idx = wrap_add(hit_ptr, k);
      end
    end
  end

  assign chunk_len = (remaining < CHUNK_SIZE) ? remaining : CHUNK_SIZE;
  assign disp_go   = (state == S_DISPATCH) && (remaining != 32'h0) && grant_vld;
  assign hit_go    = hit_vld && !bus.out_full;

  always_comb begin
    start_w = '0;
    if (disp_go) start_w[grant_idx] = 1'b1;
  end

  assign bus.core_start   = start_w;
  assign bus.core_base    = disp_go ? next_base : 32'h0;
  assign bus.core_len     = disp_go ? chunk_len : 32'h0;
  assign bus.request_data = rst_n && !bus.q_empty && ((state == S_IDLE) || (state == S_LEN_REQ));
  assign bus.busy         = (state != S_IDLE);

  // Pending hits outrank the done/error packet that is waiting on the same port.
  always_comb begin
    bus.out_data = '0;
    bus.w_en     = 1'b0;
    if (hit_vld) begin
      bus.out_data = {8'hA1, job_id, nonce_q[hit_idx]};
      bus.w_en     = !bus.out_full;
    end else if (state == S_DONE) begin
      bus.out_data = {8'hD0, job_id, hit_count};
      bus.w_en     = !bus.out_full;
    end else if (state == S_ERR) begin
      bus.out_data = {8'hEE, err_op, 32'h0};
      bus.w_en     = !bus.out_full;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (!bus.q_empty) state_nx = S_HDR;
      S_HDR:      state_nx = (bus.in_data[47:40] == 8'h01) ? S_LEN_REQ : S_ERR;
      S_LEN_REQ:  if (!bus.q_empty) state_nx = S_LEN;
      S_LEN:      state_nx = S_DISPATCH;
      S_DISPATCH: if (remaining == 32'h0) state_nx = S_DRAIN;
      S_DRAIN:    if ((&bus.core_idle) && !(|pend)) state_nx = S_DONE;
      S_DONE,
      S_ERR:      if (!hit_vld && !bus.out_full) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      job_id     <= '0;
      err_op     <= '0;
      next_base  <= '0;
      remaining  <= '0;
      hit_count  <= '0;
      rr_ptr     <= '0;
      hit_ptr    <= '0;
      pend       <= '0;
      last_start <= '0;
      for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
    end else begin
      state      <= state_nx;
      last_start <= start_w;
      if (state == S_HDR) begin
        job_id    <= bus.in_data[39:32];
        err_op    <= bus.in_data[47:40];
        next_base <= bus.in_data[31:0];
      end
      if (disp_go) begin
        next_base <= next_base + chunk_len;
        remaining <= remaining - chunk_len;
        rr_ptr    <= wrap_add(grant_idx, 1);
      end
      // A fresh report wins over the clear of the one being drained this cycle.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (hit_go && (hit_idx == PW'(i))) pend[i] <= 1'b0;
        if (bus.core_found[i]) begin
          pend[i]    <= 1'b1;
          nonce_q[i] <= bus.core_nonce[32*i +: 32];
        end
      end
      if (hit_go) begin
        hit_count <= hit_count + 32'h1;
        hit_ptr   <= wrap_add(hit_idx, 1);
      end
      if (state == S_LEN) begin
        remaining <= bus.in_data[31:0];
        hit_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bithash_job_scheduler.sv
// Directed bench for bithash_job_scheduler with queued expectations checked by a monitor.
// Uses CHUNK_SIZE = 0x10 so every range scenario stays a handful of chunks.
module tb_bithash_job_scheduler;
  localparam int NC = 4;

  typedef struct {
    int          core;
    logic [31:0] base;
    logic [31:0] len;
  } start_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  start_t      exp_start [$];
  logic [47:0] exp_pkt [$];
  logic [47:0] rq [$];
  int          busy_cnt [NC];
  logic        feed_req;
  logic [NC-1:0] model_start;
  logic        model_rs;

  always #5 clk = ~clk;

  bithash_job_scheduler_if #(.NUM_CORES(NC), .DATA_WIDTH(48)) ifc ();

  bithash_job_scheduler #(
    .NUM_CORES(NC), .DATA_WIDTH(48), .CHUNK_SIZE(32'h10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  // Read-queue model: data appears in the cycle after request_data.
  initial begin
    ifc.q_empty = 1'b1;
    ifc.in_data = '0;
    forever begin
      @(negedge clk);
      feed_req = ifc.request_data;
      @(posedge clk);
      #1;
      if (feed_req && rq.size() > 0) ifc.in_data = rq.pop_front();
      ifc.q_empty = (rq.size() == 0);
    end
  end

  // Core model: busy for six cycles after each start, reset alongside the scheduler.
  initial begin
    ifc.core_idle = '1;
    for (int i = 0; i < NC; i++) busy_cnt[i] = 0;
    forever begin
      @(negedge clk);
      model_start = ifc.core_start;
      model_rs    = rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
        if (!model_rs) busy_cnt[i] = 0;
        else if (model_start[i]) busy_cnt[i] = 6;
        else if (busy_cnt[i] > 0) busy_cnt[i] = busy_cnt[i] - 1;
        ifc.core_idle[i] = (busy_cnt[i] == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or a packet.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.core_start != '0) begin
          int idx;
          idx = -1;
          for (int i = 0; i < NC; i++) if (ifc.core_start[i]) idx = i;
          total++;
          if (exp_start.size() == 0) begin
            bad++;
            $display("FAIL start_unexpected: core_start=%b base=%h len=%h, required none",
                     ifc.core_start, ifc.core_base, ifc.core_len);
          end else begin
            start_t e;
            e = exp_start.pop_front();
            if (!$onehot(ifc.core_start) || idx != e.core || ifc.core_base !== e.base || ifc.core_len !== e.len) begin
              bad++;
              $display("FAIL start: core_start=%b base=%h len=%h, required core=%0d base=%h len=%h",
                       ifc.core_start, ifc.core_base, ifc.core_len, e.core, e.base, e.len);
            end
          end
        end
        if (ifc.w_en) begin
          total++;
          if (ifc.out_full) begin
            bad++;
            $display("FAIL w_en_while_full: w_en=1 out_full=1, required w_en=0");
          end else if (exp_pkt.size() == 0) begin
            bad++;
            $display("FAIL pkt_unexpected: out_data=%h, required none", ifc.out_data);
          end else begin
            logic [47:0] e;
            e = exp_pkt.pop_front();
            if (ifc.out_data !== e) begin
              bad++;
              $display("FAIL pkt: out_data=%h, required %h", ifc.out_data, e);
            end
          end
        end
        if (ifc.request_data && ifc.q_empty) begin
          total++;
          bad++;
          $display("FAIL request_when_empty: request_data=1 q_empty=1, required request_data=0");
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_request_data"}, 64'(ifc.request_data), 64'h0);
    chk({tag, "_w_en"},         64'(ifc.w_en),         64'h0);
    chk({tag, "_core_start"},   64'(ifc.core_start),   64'h0);
    chk({tag, "_core_base"},    64'(ifc.core_base),    64'h0);
    chk({tag, "_core_len"},     64'(ifc.core_len),     64'h0);
    chk({tag, "_out_data"},     64'(ifc.out_data),     64'h0);
    chk({tag, "_busy"},         64'(ifc.busy),         64'h0);
  endtask

  task automatic push_job(input logic [7:0] id, input logic [31:0] base, input logic [31:0] len);
    rq.push_back({8'h01, id, base});
    rq.push_back({16'hBEEF, len});
  endtask

  task automatic exp_s(input int core, input logic [31:0] base, input logic [31:0] len);
    start_t s;
    s.core = core;
    s.base = base;
    s.len  = len;
    exp_start.push_back(s);
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int n;
    n = 0;
    while ((exp_start.size() != 0 || exp_pkt.size() != 0 || rq.size() != 0 || ifc.busy) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= maxc) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: starts_left=%0d pkts_left=%0d, required 0 and 0",
               name, exp_start.size(), exp_pkt.size());
      exp_start.delete();
      exp_pkt.delete();
    end
  endtask

  initial begin
    ifc.out_full   = 1'b0;
    ifc.core_found = '0;
    ifc.core_nonce = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three chunks from base 0 to cores 0,1,2.
    push_job(8'h01, 32'h0, 32'h30);
    exp_s(0, 32'h00, 32'h10);
    exp_s(1, 32'h10, 32'h10);
    exp_s(2, 32'h20, 32'h10);
    exp_pkt.push_back(48'hD0_01_0000_0000);
    wait_empty("basic", 80);

    // Base wraps through zero; arbitration resumes at core 3.
    push_job(8'h02, 32'hFFFF_FFF0, 32'h20);
    exp_s(3, 32'hFFFF_FFF0, 32'h10);
    exp_s(0, 32'h0000_0000, 32'h10);
    exp_pkt.push_back(48'hD0_02_0000_0000);
    wait_empty("wrap", 80);

    // Short tail chunk.
    push_job(8'h03, 32'h100, 32'h15);
    exp_s(1, 32'h100, 32'h10);
    exp_s(2, 32'h110, 32'h05);
    exp_pkt.push_back(48'hD0_03_0000_0000);
    wait_empty("tail", 80);

    // Empty range: done only, no dispatch.
    push_job(8'h04, 32'h55, 32'h0);
    exp_pkt.push_back(48'hD0_04_0000_0000);
    wait_empty("zero_len", 80);

    // Bad opcode, then a normal START.
    rq.push_back({8'h7F, 8'h09, 32'h1234});
    push_job(8'h05, 32'h200, 32'h10);
    exp_pkt.push_back(48'hEE_7F_0000_0000);
    exp_s(3, 32'h200, 32'h10);
    exp_pkt.push_back(48'hD0_05_0000_0000);
    wait_empty("error", 100);

    // Simultaneous hits from all cores held off by out_full, then drained in core order.
    ifc.out_full = 1'b1;
    push_job(8'h06, 32'h1000, 32'h40);
    exp_s(0, 32'h1000, 32'h10);
    exp_s(1, 32'h1010, 32'h10);
    exp_s(2, 32'h1020, 32'h10);
    exp_s(3, 32'h1030, 32'h10);
    exp_pkt.push_back(48'hA1_06_0000_0011);
    exp_pkt.push_back(48'hA1_06_0000_0022);
    exp_pkt.push_back(48'hA1_06_0000_0033);
    exp_pkt.push_back(48'hA1_06_0000_0044);
    exp_pkt.push_back(48'hD0_06_0000_0004);
    repeat (8) @(posedge clk);
    #1;
    ifc.core_found = 4'hF;
    ifc.core_nonce = {32'h44, 32'h33, 32'h22, 32'h11};
    @(posedge clk);
    #1;
    ifc.core_found = '0;
    ifc.core_nonce = '0;
    repeat (3) @(posedge clk);
    #1;
    ifc.out_full = 1'b0;
    wait_empty("hits", 100);

    // Reset while chunks remain to dispatch.
    push_job(8'h07, 32'h0, 32'h100);
    exp_s(0, 32'h00, 32'h10);
    exp_s(1, 32'h10, 32'h10);
    exp_s(2, 32'h20, 32'h10);
    exp_s(3, 32'h30, 32'h10);
    for (int n = 0; n < 40 && exp_start.size() != 0; n++) @(posedge clk);
    chk("midjob_starts_seen", 64'(exp_start.size()), 64'h0);
    chk("midjob_busy", 64'(ifc.busy), 64'h1);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midreset");
    exp_start.delete();
    exp_pkt.delete();
    rq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Arbitration restarts at core 0.
    push_job(8'h08, 32'h40, 32'h20);
    exp_s(0, 32'h40, 32'h10);
    exp_s(1, 32'h50, 32'h10);
    exp_pkt.push_back(48'hD0_08_0000_0000);
    wait_empty("post_reset", 80);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bithash_job_scheduler.md
# bithash_job_scheduler

Sequences the BitHash datapath: pulls job commands from the BitHash RAH read queue, splits each nonce range into fixed-size chunks, and dispatches them round-robin to a bank of identical hash cores. It also collects found-nonce reports and emits result and completion packets into the RAH encoder write port. It sits between the RAH decoder/encoder queues and the hash cores, inside the `bitcoin_clk` domain.

## Interface
- `NUM_CORES`, 4: number of hash cores, 1–8.
- `DATA_WIDTH`, 48: RAH packet width; fixed at 48.
- `CHUNK_SIZE`, 32'h0010_0000: nonces per dispatched chunk; must be nonzero.

Ports:
- `clk` in 1: `bitcoin_clk`; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_data` in 48: RAH read-queue data, valid 1 cycle after `request_data`.
- `q_empty` in 1: read queue empty.
- `request_data` out 1: read strobe; asserted only when `!q_empty`.
- `out_data` out 48: packet to the RAH encoder.
- `w_en` out 1: write strobe for `out_data`.
- `out_full` in 1: encoder FIFO full; `w_en` is never asserted while it is high.
- `core_start` out NUM_CORES: one-hot, 1-cycle start pulse.
- `core_base` out 32: first nonce of the chunk; shared bus, valid with `core_start`.
- `core_len` out 32: nonces in the chunk; shared bus, valid with `core_start`.
- `core_idle` in NUM_CORES: core can accept a chunk.
- `core_found` in NUM_CORES: 1-cycle pulse per hit.
- `core_nonce` in 32*NUM_CORES: hit nonce, valid with `core_found`.
- `busy` out 1: a job is in progress (any state other than IDLE).

## Operation
- Command word layout: [47:40] opcode, [39:32] job_id, [31:0] arg.
- Opcode 0x01 (START): arg is `nonce_base`. The next queue word's [31:0] is the range length L, and its other bits are ignored.
- Any other opcode: emit the error packet {8'hEE, opcode, 32'h0} and return to IDLE.
- Output packets:
  - Hit: {8'hA1, job_id, nonce}.
  - Done: {8'hD0, job_id, hit_count[31:0]}.
- States:
  - IDLE: if `!q_empty`, pulse `request_data` and go to HDR.
  - HDR: latch the word. On opcode 0x01, go to LEN_REQ. Otherwise go to ERR.
  - LEN_REQ: wait for `!q_empty`, pulse `request_data`, then go to LEN.
  - LEN: latch L into `remaining`, set `next_base = nonce_base`, clear `hit_count`, then go to DISPATCH.
  - DISPATCH:
    - While `remaining != 0`, each cycle search from `rr_ptr` for the first core with `core_idle` set and no start issued in the previous cycle.
    - On a match, pulse its `core_start` with `core_base = next_base` and `core_len = min(CHUNK_SIZE, remaining)`.
    - Then update `next_base += core_len` (mod 2^32, wraps) and `remaining -= core_len`, and set `rr_ptr` to the granted core + 1 (mod NUM_CORES).
    - When `remaining == 0`, go to DRAIN.
  - DRAIN: wait until all `core_idle` are high and no hit is pending, then go to DONE.
  - DONE: hold the done packet until accepted, then go to IDLE.
  - ERR: hold the error packet until accepted, then go to IDLE.
- L == 0: no dispatch; emit the done packet with count 0.
- Hit capture:
  - Each core has a pending flag plus a 32-bit nonce register, set on `core_found` in any state.
  - Hits are drained one per cycle, round-robin (separate pointer), as hit packets whenever `!out_full`. Each accepted hit increments `hit_count`.
  - Hit packets take priority over done and error packets.
  - A second `core_found` from a core whose flag is still pending overwrites the nonce and still counts once. This is a documented loss; cores must not hit faster than 1 per NUM_CORES cycles.
- A packet is accepted in the cycle `w_en` = 1. `out_data` is stable whenever `w_en` = 1.

## Timing
- Reset: all outputs are 0 (`request_data`, `w_en`, `core_start`, `core_base`, `core_len`, `out_data`, `busy`). State is IDLE, both RR pointers are 0, all pending flags are clear, and counters are 0.
- Reset mid-job clears all state. Cores are not signalled, so the system reset must reset the cores too.
- Queue latency: data is sampled exactly 1 cycle after `request_data`.
- First `core_start` occurs 4 cycles after the START word is requested, provided the LEN word is already queued and core 0 is idle.
- Dispatch throughput is at most one chunk per cycle. A granted core is excluded for 1 cycle so that `core_idle` can deassert.
- Hit latency: a `core_found` in cycle t can produce `w_en` at t+1 at the earliest.
- A simultaneous `core_found` from all cores is fully captured, then drained in NUM_CORES cycles when `!out_full`.
- `busy` is high from HDR through the cycle the done or error packet is accepted.

## Test plan
- START base 32'h0000_0000, L = 0x0030_0000, 4 idle cores → `core_start` to cores 0, 1, 2 on consecutive cycles with bases 0x0, 0x10_0000, 0x20_0000 and len 0x10_0000 each; then done packet {D0, id, 0}.
- START base 32'hFFFF_FFF0, L = 0x20, CHUNK_SIZE = 0x10 → chunks at 0xFFFF_FFF0 and 0x0000_0000 (wrap), len 0x10 each.
- L = 0x15, CHUNK_SIZE = 0x10 → lens 0x10 then 0x05. L = 0 → done packet with no `core_start`.
- All 4 cores pulse `core_found` in the same cycle (nonces 0x11, 0x22, 0x33, 0x44) with `out_full` high for 3 cycles → after release, 4 hit packets in core order, then done with count 4.
- Opcode 0x7F → error packet {EE, 7F, 0}; a following valid START is processed normally.
- `rst_n` low during DISPATCH → all outputs 0 the next cycle; after release, a new START restarts with `rr_ptr` = 0.
